systolic_feed_ctrl: RTL and testbench
=====================================

// Module: systolic_feed_ctrl
// PURPOSE
//  Read sequencer between the per-row operand RAM banks and the west/north edge of the
//  4x4 systolic array. On start, streams addresses 0..LENGTH-1 to all banks in lockstep,
//  absorbs the 1-cycle RAM read latency, and presents one packed row-vector per beat to
//  the array with a valid strobe. Supports array back-pressure (stall) and signals done.
// PARAMETERS
//  DATA_W    16  width of one RAM word / one array operand
//  ADDR_W    4   RAM address width
//  LENGTH    16  words streamed per run; legal range 1..2**ADDR_W
//  NUM_ROWS  4   number of RAM banks fed in parallel (one per array row)
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  asynchronous reset, active-high
//  start      in   1                  begin a run; sampled only in IDLE
//  stall      in   1                  array not accepting; freezes issue and capture
//  ram_en     out  1                  enable to all banks (we tied 0 by integrator)
//  ram_addr   out  ADDR_W             shared read address to all banks
//  ram_do     in   NUM_ROWS*DATA_W    packed bank outputs, bank 0 in LSBs
//  feed_data  out  NUM_ROWS*DATA_W    registered operand vector to array
//  feed_valid out  1                  feed_data holds a new beat this cycle
//  beat_cnt   out  ADDR_W+1           beats delivered in current/last run
//  busy       out  1                  high in RUN, DRAIN, DONE
//  done       out  1                  one-cycle pulse on final beat
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; ram_addr=0, ram_en=0, feed_data=0, feed_valid=0,
//   beat_cnt=0, busy=0, done=0, rd_pending=0. Reset mid-run aborts; no partial done.
//  FSM: IDLE -start-> RUN (ram_addr<=0, beat_cnt<=0). RUN -last address issued-> DRAIN.
//   DRAIN -final capture-> DONE. DONE -> IDLE unconditionally after one cycle.
//   start outside IDLE ignored; start held high re-triggers only after return to IDLE.
//  ram_en = (state==RUN) & ~stall, combinational. Banks read on the edge ram_en is high;
//   bank output holds while ram_en low (relied upon during stall).
//  Issue: each edge with ram_en=1: ram_addr<=ram_addr+1 (except on address LENGTH-1:
//   ram_addr holds, state<=DRAIN); rd_pending<=1. ram_en=0 & ~stall: rd_pending<=0.
//   stall=1: ram_addr, rd_pending, feed_data held.
//  Capture: edge with rd_pending & ~stall: feed_data<=ram_do, feed_valid<=1,
//   beat_cnt<=beat_cnt+1. Otherwise feed_valid<=0 (feed_data holds last value).
//  DRAIN->DONE on the edge capturing the last beat; done=(state==DONE), coincides with
//   final feed_valid. feed_valid never asserted while stall was high at prior edge.
//  Latency, no stall: start at edge 0; RAM reads addr k at edge k+1; feed_valid high in
//   cycles after edges 2..LENGTH+1 (exactly LENGTH beats); done after edge LENGTH+1;
//   IDLE after edge LENGTH+2. Each stall cycle adds exactly one cycle, no beat lost/dup.
//  LENGTH=1: RUN lasts one issue then DRAIN directly; one beat, done with it.
//  beat_cnt saturates by construction at LENGTH; holds after run until next start.
// TESTING
//  1 Banks preloaded (bank0 words 0..15 = 0,0,0,0,0,0,0,0,0,1,4,7,2,5,8,0), start pulse,
//    stall=0 -> 16 consecutive feed_valid beats, bank0 lane = preload order, done with
//    16th beat, beat_cnt=16, busy low 1 cycle later.
//  2 stall high 3 cycles after 5th beat -> ram_en low, ram_addr frozen, no feed_valid for
//    3 cycles, then beat 6 = word 5; total 16 beats, done 3 cycles later than test 1.
//  3 stall held from start edge for 4 cycles -> ram_en 0, no beats; resumes from addr 0.
//  4 start re-pulsed during RUN and DONE -> ignored; beat_cnt ends 16, single done.
//  5 rst asserted asynchronously at beat 8 -> all outputs 0 immediately; next start runs
//    full 16 beats from addr 0.
//  6 LENGTH=1 build -> one beat (word 0) with done, busy high 3 cycles total.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// Read sequencer feeding the systolic array edge: streams addresses 0..LENGTH-1 to all
// operand banks, absorbs the 1-cycle RAM read latency and presents one row-vector per beat.
module systolic_feed_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int LENGTH   = 16,
    parameter int NUM_ROWS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stall,
    output logic                       ram_en,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic [NUM_ROWS*DATA_W-1:0] ram_do,
    output logic [NUM_ROWS*DATA_W-1:0] feed_data,
    output logic                       feed_valid,
    output logic [ADDR_W:0]            beat_cnt,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

    state_t state, state_nx;
    logic   rd_pending;
    logic   capture;
    logic   last_addr;

    assign capture   = rd_pending & ~stall;
    assign last_addr = (ram_addr == LAST_ADDR);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN only ever holds the final outstanding read, so its capture ends the run.
    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                ram_en = ~stall;
                if (~stall && last_addr) state_nx = DRAIN;
            end
            DRAIN: begin
                if (capture) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Issue side: address walk and the read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr   <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ram_addr <= '0;
            end else if (ram_en && !last_addr) begin
                ram_addr <= ram_addr + 1'b1;
            end
            if (ram_en) begin
                rd_pending <= 1'b1;
            end else if (!stall) begin
                rd_pending <= 1'b0;
            end
        end
    end

    // Capture side: bank output is held by the RAM while stalled, so it is safe to take late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feed_data  <= '0;
            feed_valid <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            feed_valid <= capture;
            if (capture) begin
                feed_data <= ram_do;
            end
            if (state == IDLE && start) begin
                beat_cnt <= '0;
            end else if (capture) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: count-based transaction model checked every
// cycle, plus hand-computed latency/lane expectations for stall, restart, reset and LENGTH=1.
module tb_systolic_feed_ctrl;

    localparam int L = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stall = 1'b0;
    logic        start1 = 1'b0, stall1 = 1'b0;
    logic        ram_en, ram_en1;
    logic [3:0]  ram_addr, ram_addr1;
    logic [63:0] ram_do = '0, ram_do1 = '0;
    logic [63:0] feed_data, feed_data1;
    logic        feed_valid, feed_valid1;
    logic [4:0]  beat_cnt, beat_cnt1;
    logic        busy, busy1, done, done1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] mem  [4][16];
    logic [15:0] mem1 [4][16];
    logic [15:0] exp0 [16] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                               16'd0, 16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd0};

    systolic_feed_ctrl #(.DATA_W(16), .ADDR_W(4), .LENGTH(16), .NUM_ROWS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_do(ram_do),
        .feed_data(feed_data), .feed_valid(feed_valid), .beat_cnt(beat_cnt),
        .busy(busy), .done(done)
    );

    systolic_feed_ctrl #(.DATA_W(16), .ADDR_W(4), .LENGTH(1), .NUM_ROWS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stall(stall1),
        .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_do(ram_do1),
        .feed_data(feed_data1), .feed_valid(feed_valid1), .beat_cnt(beat_cnt1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM banks; output holds while not enabled
    always @(posedge clk) begin
        if (ram_en) for (int r = 0; r < 4; r++) ram_do[r*16 +: 16] <= mem[r][ram_addr];
        if (ram_en1) for (int r = 0; r < 4; r++) ram_do1[r*16 +: 16] <= mem1[r][ram_addr1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: a run is "issued" reads and "captured" beats; at most one read is in flight.
    bit          m_act, m_dn, m_fv;
    int          m_iss, m_cap, m_beats, m_addr;
    logic [63:0] m_data;

    function automatic logic [63:0] vec(input int idx);
        logic [63:0] v;
        for (int r = 0; r < 4; r++) v[r*16 +: 16] = mem[r][idx];
        return v;
    endfunction

    task automatic mreset();
        m_act = 0; m_dn = 0; m_fv = 0;
        m_iss = 0; m_cap = 0; m_beats = 0; m_addr = 0; m_data = '0;
    endtask

    task automatic mstep(input bit st, input bit sa);
        bit pa, pd, en;
        int pi, pc;
        pa = m_act; pd = m_dn; pi = m_iss; pc = m_cap;
        m_fv = pa && (pi > pc) && !st;
        en   = pa && (pi < L) && !st;
        m_dn = 0;
        if (m_fv) begin
            m_data = vec(pc);
            m_cap = pc + 1;
            m_beats++;
            if (m_cap == L) begin
                m_dn = 1;
                m_act = 0;
            end
        end
        if (en) begin
            m_iss = pi + 1;
            m_addr = (pi < L - 1) ? pi + 1 : L - 1;
        end
        if (!pa && !pd && sa) begin
            m_act = 1; m_iss = 0; m_cap = 0; m_beats = 0; m_addr = 0;
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) mreset();
            else mstep(stall, start);
            @(negedge clk);
            if (rst) mreset();
            chk("m_ram_en", ram_en, m_act && (m_iss < L) && !stall);
            chk("m_ram_addr", ram_addr, m_addr);
            chk("m_feed_valid", feed_valid, m_fv);
            chk("m_feed_data", feed_data, m_data);
            chk("m_beat_cnt", beat_cnt, m_beats);
            chk("m_busy", busy, m_act || m_dn);
            chk("m_done", done, m_dn);
        end
    end

    int nb, ndone, done_edge, s_edge;
    logic [15:0] q[$];

    task automatic step();
        @(negedge clk);
        #2;
        start = 0;
        stall = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_feed_data"}, feed_data, 0);
        chk({tag, "_feed_valid"}, feed_valid, 0);
        chk({tag, "_beat_cnt"}, beat_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // stall_at>0: stall after that beat; stall_at<0: stall from the start edge.
    task automatic run(input int stall_at, input int stall_len, input bit poke, input int rst_at);
        int scnt;
        logic [3:0] frozen;
        q.delete();
        nb = 0; ndone = 0; done_edge = -1; scnt = 0; frozen = '0;
        start = 1;
        s_edge = cyc + 1;
        if (stall_at < 0) begin
            stall = 1;
            scnt = stall_len;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (feed_valid) begin
                q.push_back(feed_data[15:0]);
                nb++;
            end
            if (done) begin
                done_edge = cyc;
                ndone++;
            end
            if (stall) chk("stall_no_ram_en", ram_en, 0);
            if (rst_at > 0 && feed_valid && nb == rst_at) begin
                rst = 1;
                #1;
                chk_zero("async_rst");
                return;
            end
            #1;
            start = 0;
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    stall = 0;
                    chk("stall_addr_held", ram_addr, frozen);
                end
            end else if (stall_at > 0 && feed_valid && nb == stall_at) begin
                stall = 1;
                scnt = stall_len;
                frozen = ram_addr;
                chk("stall_addr", ram_addr, stall_at + 1);
            end
            if (poke && ((feed_valid && nb == 3) || done)) start = 1;
            if (done) break;
        end
        chk("done_seen", ndone, 1);
    endtask

    task automatic chk_lane(input string tag);
        chk({tag, "_nbeats"}, q.size(), 16);
        if (q.size() == 16)
            for (int i = 0; i < 16; i++) chk({tag, "_lane0"}, q[i], exp0[i]);
    endtask

    initial begin
        int n1, nd1, nbusy1;
        for (int r = 0; r < 4; r++)
            for (int a = 0; a < 16; a++) begin
                mem[r][a]  = (r == 0) ? exp0[a] : 16'(16'h1100 * r + a);
                mem1[r][a] = (a == 0) ? 16'(16'hA000 + r) : 16'h5555;
            end

        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        #2;
        rst = 0;

        // 1: clean run
        run(0, 0, 0, 0);
        chk("t1_beats", nb, 16);
        chk("t1_latency", done_edge - s_edge, 17);
        chk("t1_beat_cnt", beat_cnt, 16);
        chk_lane("t1");
        step();
        chk("t1_busy_after", busy, 0);
        chk("t1_beat_cnt_hold", beat_cnt, 16);

        // 2: three stall cycles after beat 5
        run(5, 3, 0, 0);
        chk("t2_beats", nb, 16);
        chk("t2_latency", done_edge - s_edge, 20);
        chk_lane("t2");
        step();
        chk("t2_busy_after", busy, 0);

        // 3: stall from the start edge
        run(-1, 5, 0, 0);
        chk("t3_beats", nb, 16);
        chk("t3_latency", done_edge - s_edge, 21);
        chk_lane("t3");
        step();

        // 4: start re-pulsed in RUN and in DONE
        run(0, 0, 1, 0);
        chk("t4_latency", done_edge - s_edge, 17);
        chk("t4_beats", nb, 16);
        step();
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) ndone++;
            chk("t4_stays_idle", busy, 0);
        end
        chk("t4_single_done", ndone, 1);
        chk("t4_beat_cnt", beat_cnt, 16);
        step();

        // 5: async reset at beat 8, then a full run from address 0
        run(0, 0, 0, 8);
        @(negedge clk);
        #2;
        rst = 0;
        chk("t5_beat_cnt_cleared", beat_cnt, 0);
        run(0, 0, 0, 0);
        chk("t5_latency", done_edge - s_edge, 17);
        chk_lane("t5");
        step();

        // 6: LENGTH=1 instance
        n1 = 0; nd1 = 0; nbusy1 = 0;
        start1 = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (feed_valid1) begin
                n1++;
                chk("t6_data", feed_data1, 64'hA003_A002_A001_A000);
            end
            if (done1) begin
                nd1++;
                chk("t6_done_with_beat", feed_valid1, 1);
            end
            if (busy1) nbusy1++;
            #1;
            start1 = 0;
        end
        chk("t6_beats", n1, 1);
        chk("t6_dones", nd1, 1);
        chk("t6_busy_cycles", nbusy1, 3);
        chk("t6_beat_cnt", beat_cnt1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
